// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage core: hazard sequencer state encoding and register-select type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  // Register-select width used across the core.
  localparam int REGBITS_W = 5;

  typedef logic [REGBITS_W-1:0] regbits_t;

  // Hazard control unit sequencer states. The encoding is visible on state_o for debug.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hcu_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard sequencer bundle: pipeline hazard status in, latch/PC control out.
// Latency: n/a (wires only).
// Backpressure: n/a. The slave modport is the sequencer and the master modport is the pipeline.
// Optional HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
interface hazard_control_unit_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  // Pipeline status
  logic             ihit;
  logic             dhit;
  logic             dmemREN_mem;
  logic             dmemWEN_mem;
  logic             memread_ex;
  logic [REG_W-1:0] wsel_ex;
  logic [REG_W-1:0] rsel1_id;
  logic [REG_W-1:0] rsel2_id;
  logic             uses_rt_id;
  logic             branch_taken_mem;
  logic             jump_ex;
  logic             halt_wb;
  logic             dflush_done;
  // Sequencer controls
  logic             pc_en;
  logic             en_ifid;
  logic             en_idex;
  logic             en_exmem;
  logic             en_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             dflush_req;
  logic             halt;
  logic [1:0]       state_o;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
`endif

  modport slave (
    input  ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex, wsel_ex,
           rsel1_id, rsel2_id, uses_rt_id, branch_taken_mem, jump_ex,
           halt_wb, dflush_done,
    output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, dflush_req, halt, state_o
`ifdef HAZARD_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport master (
    output ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex, wsel_ex,
           rsel1_id, rsel2_id, uses_rt_id, branch_taken_mem, jump_ex,
           halt_wb, dflush_done,
    input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, dflush_req, halt, state_o
`ifdef HAZARD_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_control_unit_detect.sv
// Combinational hazard terms: dcache wait, load-use dependency and control-flow redirect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. The terms are consumed by the sequencer in the same cycle.
// Ports: MEM-stage access/dhit, EX load and destination, ID sources, redirect sources in; memwait/loaduse/redirect out.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memread_ex,
  input  logic [REG_W-1:0] wsel_ex,
  input  logic [REG_W-1:0] rsel1_id,
  input  logic [REG_W-1:0] rsel2_id,
  input  logic             uses_rt_id,
  input  logic             branch_taken_mem,
  input  logic             jump_ex,
  output logic             memwait,
  output logic             loaduse,
  output logic             redirect
);

  assign memwait = (dmemREN_mem | dmemWEN_mem) & ~dhit;

  // Writes to $zero are discarded, so a load targeting it never creates a dependency.
  assign loaduse = memread_ex & (wsel_ex != '0) &
                   ((wsel_ex == rsel1_id) | (uses_rt_id & (wsel_ex == rsel2_id)));

  assign redirect = branch_taken_mem | jump_ex;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stall/freeze/flush/halt control for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC.
// Latency: controls are combinational from state and inputs. The state advances one cycle per edge.
// Backpressure: a dcache wait freezes every latch, and the HALT drain waits on dflush_done.
// Ports: CLK, RST (synchronous, active-high), hif (slave modport of hazard_control_unit_if).
// Optional HAZARD_PERF_EN adds the stall_cnt/flush_cnt saturating counters.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  hazard_control_unit_if.slave  hif
);

  hcu_state_t state, state_n;

  logic memwait, loaduse, redirect;
  logic apply_run;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem;
  logic dflush_req, halt;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .dhit             (hif.dhit),
    .dmemREN_mem      (hif.dmemREN_mem),
    .dmemWEN_mem      (hif.dmemWEN_mem),
    .memread_ex       (hif.memread_ex),
    .wsel_ex          (hif.wsel_ex),
    .rsel1_id         (hif.rsel1_id),
    .rsel2_id         (hif.rsel2_id),
    .uses_rt_id       (hif.uses_rt_id),
    .branch_taken_mem (hif.branch_taken_mem),
    .jump_ex          (hif.jump_ex),
    .memwait          (memwait),
    .loaduse          (loaduse),
    .redirect         (redirect)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    apply_run   = 1'b0;
    pc_en       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    dflush_req  = 1'b0;
    halt        = 1'b0;

    case (state)
      RUN: begin
        if (hif.halt_wb) begin
          dflush_req = 1'b1;
          state_n    = DRAIN;
        end else if (memwait) begin
          state_n = MEMWAIT;
        end else begin
          apply_run = 1'b1;
        end
      end
      MEMWAIT: begin
        // The frozen latches hold every input, so when the access completes the
        // pending redirect/load-use/fetch decisions are resolved in this same cycle.
        if (!memwait) begin
          apply_run = 1'b1;
          state_n   = RUN;
        end
      end
      DRAIN: begin
        // dflush_done is only looked at from here, so a done pulse coincident with
        // halt_wb (the entry cycle) is never mistaken for completion.
        dflush_req = 1'b1;
        if (hif.dflush_done) state_n = HALTED;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: state_n = RUN;
    endcase

    if (apply_run) begin
      if (redirect) begin
        // A taken branch in MEM is older than a jump in EX, so it additionally squashes EX/MEM.
        pc_en       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = hif.branch_taken_mem;
      end else if (loaduse) begin
        // Hold PC and IF/ID and inject one bubble into ID/EX. The load moves on to MEM
        // next cycle, so the dependency clears without further tracking.
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_idex = 1'b1;
      end else if (!hif.ihit) begin
        en_ifid    = 1'b1;
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_ifid = 1'b1;
      end else begin
        pc_en    = 1'b1;
        en_ifid  = 1'b1;
        en_idex  = 1'b1;
        en_exmem = 1'b1;
        en_memwb = 1'b1;
      end
    end

    if (RST) begin
      state_n     = RUN;
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      dflush_req  = 1'b0;
      halt        = 1'b0;
    end
  end

  assign hif.pc_en       = pc_en;
  assign hif.en_ifid     = en_ifid;
  assign hif.en_idex     = en_idex;
  assign hif.en_exmem    = en_exmem;
  assign hif.en_memwb    = en_memwb;
  assign hif.flush_ifid  = flush_ifid;
  assign hif.flush_idex  = flush_idex;
  assign hif.flush_exmem = flush_exmem;
  assign hif.dflush_req  = dflush_req;
  assign hif.halt        = halt;
  assign hif.state_o     = state;

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
  logic              stall_inc, flush_inc;

  assign stall_inc = ((state == RUN) || (state == MEMWAIT)) && !pc_en;
  assign flush_inc = flush_ifid | flush_idex | flush_exmem;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state != HALTED) begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage core: owns stall, freeze, flush and halt sequencing for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC.
- Works alongside the forwarding unit. Forwarding resolves ALU-to-ALU dependencies. This block handles what forwarding cannot:
  - load-use bubbles
  - dcache/icache wait freezes
  - branch/jump redirect flushes
  - end-of-program halt with dcache flush handshake.

Parameters:
- REG_W, 5, register-select width.
- PERF_W, 32, width of the performance counters (only used with HAZARD_PERF_EN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  icache returned instruction this cycle.
- dhit  in  1  dcache completed the MEM-stage access this cycle.
- dmemREN_mem  in  1  MEM-stage load.
- dmemWEN_mem  in  1  MEM-stage store.
- memread_ex  in  1  EX-stage instruction is a load.
- wsel_ex  in  REG_W  EX-stage destination register.
- rsel1_id  in  REG_W  ID-stage source register rs.
- rsel2_id  in  REG_W  ID-stage source register rt.
- uses_rt_id  in  1  ID-stage instruction reads rt.
- branch_taken_mem  in  1  branch resolved taken in MEM.
- jump_ex  in  1  J/JAL/JR in EX.
- halt_wb  in  1  HALT instruction in WB.
- dflush_done  in  1  dcache write-back flush complete.
- pc_en  out  1  PC register load enable.
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  latch enables.
- flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous clear to bubble.
- dflush_req  out  1  request dcache flush.
- halt  out  1  core halted (sticky).
- state_o  out  2  current FSM state, for debug.

Behaviour:
- FSM states: RUN=0, MEMWAIT=1, DRAIN=2, HALTED=3. Encoding lives in the shared package.
- Reset (RST high at a clock edge):
  - state becomes RUN.
  - All enables 0, all flushes 0, dflush_req 0, halt 0.
  - Outputs are combinational from state and inputs, forced to these values while RST is high.
  - Mid-operation reset (any state, including DRAIN with dflush_req high) aborts to RUN next edge. No pending action survives.
- Hazard terms (combinational):
  - memwait = (dmemREN_mem | dmemWEN_mem) & ~dhit.
  - loaduse = memread_ex & (wsel_ex != 0) & (wsel_ex == rsel1_id | (uses_rt_id & wsel_ex == rsel2_id)).
  - redirect = branch_taken_mem | jump_ex.
- RUN priority, highest first:
  1. halt_wb: all enables 0, dflush_req 1, next state DRAIN.
  2. memwait: all enables and pc_en 0 (full freeze), next state MEMWAIT.
  3. branch_taken_mem: pc_en 1; flush_ifid, flush_idex, flush_exmem 1; all enables 1. Overrides jump_ex and loaduse.
  4. jump_ex: pc_en 1; flush_ifid, flush_idex 1; enables 1.
  5. loaduse: pc_en 0, en_ifid 0, flush_idex 1; en_exmem and en_memwb 1. Exactly one bubble per load, because the load leaves EX next cycle.
  6. ~ihit: pc_en 0; flush_ifid 1; downstream enables 1 (fetch bubble).
  7. Otherwise all enables 1, no flush.
- MEMWAIT:
  - Full freeze while memwait holds.
  - On dhit, apply the RUN rules 3–7 in that same cycle and return to RUN.
- DRAIN:
  - dflush_req held 1, all enables 0.
  - On dflush_done, go to HALTED.
  - dflush_done arriving in the same cycle as entry is ignored. It is sampled from the first DRAIN cycle.
- HALTED:
  - halt 1, all enables and pc_en 0, dflush_req 0.
  - Exit only by RST.
- Simultaneous events:
  - memwait with redirect: the freeze wins and the redirect is re-evaluated when dhit arrives. Inputs are held by the frozen latches.
  - $zero as destination never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt (PERF_W): counts cycles with pc_en 0 in RUN/MEMWAIT.
  - flush_cnt (PERF_W): counts cycles with any flush asserted.
- Both counters clear on RST, saturate at all-ones, and freeze in HALTED.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gets:
  - hcu_state_t enum (RUN, MEMWAIT, DRAIN, HALTED).
  - REG_W-sized regbits_t, reused from the package.
- Optional sub-module hazard_detect: purely combinational loaduse/memwait/redirect terms, so the bench can check them in isolation.
- The FSM and output mux stay in the top module.

Test Plan:
- Load-use: memread_ex=1, wsel_ex=8, rsel1_id=8, ihit=1 → one cycle with pc_en=0, en_ifid=0, flush_idex=1; next cycle all enables 1.
- $zero load: memread_ex=1, wsel_ex=0, rsel1_id=0 → no stall, all enables 1.
- Dcache miss: dmemREN_mem=1, dhit=0 for 3 cycles → state_o=1, all enables 0 for 3 cycles; dhit=1 → enables 1, state_o=0.
- Branch during load-use: branch_taken_mem=1 with loaduse true → flush_ifid, flush_idex, flush_exmem all 1 and pc_en=1.
- Halt: halt_wb=1 → dflush_req=1 and state_o=2; dflush_done after 5 cycles → halt=1, state_o=3. RST mid-DRAIN → state_o=0, dflush_req=0 next cycle.
- HAZARD_PERF_EN: 3-cycle miss plus one load-use bubble → stall_cnt=4; one taken branch → flush_cnt=1.
